transition_scan_ctrl: RTL and testbench

TRANSITION_SCAN_CTRL -- requirements
Module: transition_scan_ctrl

---
 rtl/transition_scan_pkg.sv | 17 +
 rtl/rr_next_ch.sv | 23 ++
 rtl/transition_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_transition_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/transition_scan_pkg.sv
// Shared state encoding and default parameters for the transition scan controller.
package transition_scan_pkg;

  localparam int unsigned N_CH_DEF    = 4;
  localparam logic [3:0]  WIN_MAX_DEF = 4'd12;
  localparam logic [1:0]  HOLD_DEF    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_ARM     = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_DET     = 3'd4,
    ST_ADV     = 3'd5
  } state_t;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin channel picker: first enabled channel strictly after last_ch,
// wrapping 3->0; last_ch itself is chosen only when it is the sole enabled one.
module rr_next_ch (
  input  logic [3:0] ch_mask,
  input  logic [1:0] last_ch,
  output logic [1:0] next_ch,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    next_ch = last_ch;
    any     = |ch_mask;
    idx     = '0;
    // Walk from farthest to nearest so the nearest enabled channel wins.
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = last_ch + 2'(k);
      if (ch_mask[idx]) next_ch = idx;
    end
  end

endmodule

// File: rtl/transition_scan_ctrl.sv
// Scans channel pairs round-robin, looking for a 00 -> 11 transition within a
// bounded window; reports detections with a pulse plus a valid/ack handshake.
module transition_scan_ctrl
  import transition_scan_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter logic [3:0]  WIN_MAX = WIN_MAX_DEF,
  parameter logic [1:0]  HOLD    = HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] in1,
  input  logic [N_CH-1:0] in2,
  input  logic            ack,
  output logic            det_out,
  output logic            det_valid,
  output logic [1:0]      det_ch,
  output logic            overrun,
  output logic            busy,
  output logic [2:0]      ps,
  output logic [3:0]      win_cnt
);

  state_t     state;
  logic [1:0] cur_ch;
  logic [1:0] last_ch;
  logic [1:0] hold_cnt;
  logic [1:0] next_ch;
  logic       any_ch;
  logic [1:0] pair;
  logic       timeout;
  logic       det_enter;
  logic [3:0] win_inc;

  rr_next_ch u_rr (
    .ch_mask (ch_mask),
    .last_ch (last_ch),
    .next_ch (next_ch),
    .any     (any_ch)
  );

  assign pair      = {in1[cur_ch], in2[cur_ch]};
  assign timeout   = (win_cnt == WIN_MAX);
  assign det_enter = (state == ST_WAIT_HI) && !timeout && (pair == 2'b11);
  assign win_inc   = timeout ? win_cnt : win_cnt + 4'd1;
  assign ps        = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      det_out   <= 1'b0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      overrun   <= 1'b0;
      win_cnt   <= '0;
      cur_ch    <= '0;
      last_ch   <= 2'd3;
      hold_cnt  <= '0;
    end else begin
      // A new result takes priority over a same-cycle acknowledge.
      if (det_enter) begin
        det_valid <= 1'b1;
        det_ch    <= cur_ch;
        if (det_valid && !ack) overrun <= 1'b1;
      end else if (ack) begin
        det_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en && any_ch) begin
            state <= ST_SEL;
            busy  <= 1'b1;
          end
        end
        ST_SEL: begin
          if (!any_ch) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cur_ch  <= next_ch;
            win_cnt <= '0;
            state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (timeout)             state <= ST_ADV;
          else if (pair == 2'b00)  state <= ST_WAIT_HI;
          else                     win_cnt <= win_inc;
        end
        ST_WAIT_HI: begin
          if (timeout) begin
            state <= ST_ADV;
          end else if (pair == 2'b11) begin
            state    <= ST_DET;
            det_out  <= 1'b1;
            hold_cnt <= HOLD - 2'd1;
          end else begin
            win_cnt <= win_inc;
            if (pair != 2'b00) state <= ST_ARM;
          end
        end
        ST_DET: begin
          if (hold_cnt == '0) begin
            state   <= ST_ADV;
            det_out <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 2'd1;
          end
        end
        ST_ADV: begin
          last_ch <= cur_ch;
          state   <= en ? ST_SEL : ST_IDLE;
          busy    <= en;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          det_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transition_scan_ctrl.sv
// Bench for transition_scan_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the scan rules.
module tb_transition_scan_ctrl;

  localparam int WIN   = 12;
  localparam int HOLDN = 3;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [3:0] ch_mask, in1, in2;
  logic       det_out, det_valid, overrun, busy;
  logic [1:0] det_ch;
  logic [2:0] ps;
  logic [3:0] win_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: states numbered 0..5 as IDLE, SEL, ARM, WAIT_HI, DET, ADV.
  int m_ps, m_win, m_cur, m_last, m_left, m_ch;
  bit m_out, m_valid, m_ovr;

  always #5 clk = ~clk;

  transition_scan_ctrl #(.N_CH(4), .WIN_MAX(4'd12), .HOLD(2'd3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch_mask   (ch_mask),
    .in1       (in1),
    .in2       (in2),
    .ack       (ack),
    .det_out   (det_out),
    .det_valid (det_valid),
    .det_ch    (det_ch),
    .overrun   (overrun),
    .busy      (busy),
    .ps        (ps),
    .win_cnt   (win_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic model_step();
    int nps;
    bit enter;
    int pr;
    if (rst) begin
      m_ps = 0; m_win = 0; m_cur = 0; m_last = 3; m_left = 0; m_ch = 0;
      m_out = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    nps = m_ps;
    enter = 0;
    case (m_ps)
      0: if (en && ch_mask != 0) nps = 1;
      1: if (ch_mask == 0) nps = 0;
         else begin m_cur = pick(ch_mask, m_last); m_win = 0; nps = 2; end
      2, 3: begin
        pr = 2 * int'(in1[m_cur]) + int'(in2[m_cur]);
        if (m_win == WIN) nps = 5;
        else if (m_ps == 3 && pr == 3) begin nps = 4; enter = 1; end
        else if (m_ps == 2 && pr == 0) nps = 3;
        else begin
          if (pr != 0) nps = 2;
          m_win = (m_win < WIN) ? m_win + 1 : WIN;
        end
      end
      4: begin
        m_left--;
        if (m_left == 0) begin nps = 5; m_out = 0; end
      end
      5: begin m_last = m_cur; nps = en ? 1 : 0; end
      default: nps = 0;
    endcase
    if (enter) begin
      m_left = HOLDN;
      m_out  = 1;
      if (m_valid && !ack) m_ovr = 1;
      m_valid = 1;
      m_ch = m_cur;
    end else if (ack) begin
      m_valid = 0;
    end
    m_ps = nps;
  endtask

  task automatic compare_all();
    check("ps", int'(ps), m_ps);
    check("det_out", int'(det_out), int'(m_out));
    check("det_valid", int'(det_valid), int'(m_valid));
    check("det_ch", int'(det_ch), m_ch);
    check("overrun", int'(overrun), int'(m_ovr));
    check("busy", int'(busy), int'(m_ps != 0));
    check("win_cnt", int'(win_cnt), m_win);
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic set_pair(input logic [1:0] p);
    in1 = {4{p[1]}};
    in2 = {4{p[0]}};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int cnt, nrise, win_exit, got_ps;
    bit prev, found;
    int seen[$];
    logic [1:0] seq [4];
    int exp_ps [4];

    rst = 1'b1; en = 1'b0; ack = 1'b0; ch_mask = '0;
    set_pair(2'b01);
    do_reset();
    check("reset_ps", int'(ps), 0);
    check("reset_busy", int'(busy), 0);

    // Single-channel detection, pulse length, valid held until ack.
    en = 1'b1; ch_mask = 4'b0001;
    cycle(); cycle();
    set_pair(2'b00); cycle();
    set_pair(2'b11); cycle();
    set_pair(2'b01);
    cnt = int'(det_out);
    for (int i = 0; i < 8; i++) begin cycle(); cnt += int'(det_out); end
    check("single_pulse_len", cnt, 3);
    check("single_det_ch", int'(det_ch), 0);
    check("single_valid_held", int'(det_valid), 1);
    ack = 1'b1; cycle(); ack = 1'b0;
    check("single_ack_clears", int'(det_valid), 0);

    // Timeout: pair 01 never arms; en dropped mid-visit must not abort it.
    do_reset();
    en = 1'b1; ch_mask = 4'b0001; set_pair(2'b01);
    cycle(); cycle();
    en = 1'b0;
    cnt = 0; win_exit = -1;
    for (int i = 0; i < 20; i++) begin
      int prev_ps, prev_win;
      prev_ps = int'(ps); prev_win = int'(win_cnt);
      cycle();
      cnt += int'(det_out);
      if (prev_ps == 2 && int'(ps) == 5) win_exit = prev_win;
    end
    check("timeout_no_det", cnt, 0);
    check("timeout_exit_win", win_exit, 12);
    check("timeout_to_idle", int'(ps), 0);

    // 00,10,00,11 -> WAIT_HI, ARM, WAIT_HI, DET then a single detection.
    do_reset();
    en = 1'b1; ch_mask = 4'b0001; set_pair(2'b01);
    cycle(); cycle();
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b00; seq[3] = 2'b11;
    exp_ps[0] = 3; exp_ps[1] = 2; exp_ps[2] = 3; exp_ps[3] = 4;
    nrise = 0;
    for (int i = 0; i < 4; i++) begin
      set_pair(seq[i]); cycle();
      check("rearm_ps", int'(ps), exp_ps[i]);
    end
    nrise = 1;
    set_pair(2'b01); en = 1'b0;
    prev = det_out;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (det_out && !prev) nrise++;
      prev = det_out;
    end
    check("rearm_single_det", nrise, 1);

    // Two channels, alternating 00/11: ch1, ch3, ch1; no ack -> overrun.
    do_reset();
    en = 1'b1; ch_mask = 4'b1010;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_pair((i % 2 == 0) ? 2'b00 : 2'b11);
      cycle();
      if (det_out && !prev) seen.push_back(int'(det_ch));
      prev = det_out;
    end
    check("rr_count_ge3", int'(seen.size() >= 3), 1);
    if (seen.size() >= 3) begin
      check("rr_first", seen[0], 1);
      check("rr_second", seen[1], 3);
      check("rr_third", seen[2], 1);
    end
    check("overrun_set", int'(overrun), 1);
    check("overrun_last_ch", int'(det_ch), seen[seen.size()-1]);

    // Ack held high: set wins on the detection edge.
    ack = 1'b1; prev = det_out;
    for (int i = 0; i < 30; i++) begin
      set_pair((i % 2 == 0) ? 2'b00 : 2'b11);
      cycle();
      if (det_out && !prev) check("set_beats_ack", int'(det_valid), 1);
      prev = det_out;
    end
    ack = 1'b0;

    // Reset during the second DET cycle.
    do_reset();
    en = 1'b1; ch_mask = 4'b0001; set_pair(2'b00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      set_pair((i % 2 == 0) ? 2'b00 : 2'b11);
      cycle();
      if (m_ps == 4) found = 1'b1;
    end
    check("det_reached", int'(found), 1);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    got_ps = int'(ps);
    check("middet_rst_ps", got_ps, 0);
    check("middet_rst_det_out", int'(det_out), 0);
    check("middet_rst_valid", int'(det_valid), 0);
    check("middet_rst_win", int'(win_cnt), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 9) != 0);
      ack     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom);
      in1     = 4'($urandom);
      in2     = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
